// File: rtl/isdu_param.sv
// Instruction sequencer / decode unit for the sLC-3 with a parametrised SRAM
// access length, a shared memory read/write engine and per-instruction status pulses.
module isdu_param #(
  parameter int MEM_WAIT = 2,
  parameter bit PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic       MIO_EN,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Instr_done,
  output logic       Illegal_op
);

  typedef enum logic [4:0] {
    S_HALTED,
    S_FETCH,
    S_MEM_RD,
    S_LOAD_IR,
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR_EVAL,
    S_BR_TAKE,
    S_JMP,
    S_JSR_LINK,
    S_JSR_PC,
    S_JSRR_PC,
    S_ADDR_PC9,
    S_ADDR_BASE6,
    S_LDI_MAR,
    S_LD_DR,
    S_ST_MDR,
    S_MEM_WR,
    S_LEA,
    S_PAUSE1,
    S_PAUSE2
  } state_e;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;      // successor once the current memory read completes
  logic [3:0] wait_q, wait_d;
  logic       ind_q, ind_d;      // indirect addressing (LDI/STI)
  logic       store_q, store_d;  // memory access of this instruction is a store
  logic       in_mem;
  logic       mem_last;

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  assign in_mem   = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_last = (wait_q == WAIT_LAST);

  // Counter restarts from zero whenever a memory state is left, so every
  // entry into MEM_RD/MEM_WR begins at zero.
  always_comb begin
    wait_d = 4'd0;
    if (in_mem && !mem_last) wait_d = wait_q + 4'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; only control registers are reset, there is no memory array.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_HALTED;
      ret_q   <= S_LOAD_IR;
      wait_q  <= 4'd0;
      ind_q   <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      ind_q   <= ind_d;
      store_q <= store_d;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case
  // statement, so no path through the block can infer a latch.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    ind_d      = ind_q;
    store_d    = store_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    MIO_EN     = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    Instr_done = 1'b0;
    Illegal_op = 1'b0;

    unique case (state_q)
      S_HALTED: begin
        if (Run) state_d = S_FETCH;
      end

      S_FETCH: begin
        GatePC  = 1'b1;
        LD_MAR  = 1'b1;
        LD_PC   = 1'b1;
        ret_d   = S_LOAD_IR;
        state_d = S_MEM_RD;
      end

      S_MEM_RD: begin
        Mem_OE = 1'b0;
        MIO_EN = 1'b1;
        if (mem_last) begin
          LD_MDR  = 1'b1;
          state_d = ret_q;
        end
      end

      S_LOAD_IR: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        LD_BEN  = 1'b1;
        ind_d   = 1'b0;
        store_d = 1'b0;
        unique case (Opcode)
          4'b0000: state_d = S_BR_EVAL;
          4'b0001: state_d = S_ADD;
          4'b0101: state_d = S_AND;
          4'b1001: state_d = S_NOT;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_JSR_LINK;
          4'b1110: state_d = S_LEA;
          4'b0010: state_d = S_ADDR_PC9;
          4'b0110: state_d = S_ADDR_BASE6;
          4'b1010: begin
            ind_d   = 1'b1;
            state_d = S_ADDR_PC9;
          end
          4'b0011: begin
            store_d = 1'b1;
            state_d = S_ADDR_PC9;
          end
          4'b0111: begin
            store_d = 1'b1;
            state_d = S_ADDR_BASE6;
          end
          4'b1011: begin
            ind_d   = 1'b1;
            store_d = 1'b1;
            state_d = S_ADDR_PC9;
          end
          4'b1101: begin
            if (PAUSE_EN) begin
              state_d = S_PAUSE1;
            end else begin
              Illegal_op = 1'b1;
              Instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          end
          default: begin
            Illegal_op = 1'b1;
            Instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_ADD, S_AND, S_NOT: begin
        SR1MUX     = 1'b1;
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        Instr_done = 1'b1;
        SR2MUX     = (state_q == S_NOT) ? 1'b0 : IR_5;
        ALUK       = (state_q == S_ADD) ? 2'b00 : (state_q == S_AND) ? 2'b01 : 2'b10;
        state_d    = S_FETCH;
      end

      S_BR_EVAL: begin
        if (BEN) begin
          state_d = S_BR_TAKE;
        end else begin
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_BR_TAKE: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b10;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JMP: begin
        SR1MUX     = 1'b1;
        ALUK       = 2'b11;
        GateALU    = 1'b1;
        PCMUX      = 2'b01;
        LD_PC      = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      // R7 <- PC, then IR[11] picks PC-relative (JSR) or base-register (JSRR) target.
      S_JSR_LINK: begin
        GatePC  = 1'b1;
        DRMUX   = 1'b1;
        LD_REG  = 1'b1;
        state_d = IR_11 ? S_JSR_PC : S_JSRR_PC;
      end

      S_JSR_PC: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b11;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_JSRR_PC: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b00;
        PCMUX      = 2'b10;
        LD_PC      = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDR_PC9, S_ADDR_BASE6: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        if (state_q == S_ADDR_BASE6) begin
          SR1MUX   = 1'b1;
          ADDR1MUX = 1'b1;
          ADDR2MUX = 2'b01;
        end else begin
          ADDR1MUX = 1'b0;
          ADDR2MUX = 2'b10;
        end
        if (ind_q) begin
          ret_d   = S_LDI_MAR;
          state_d = S_MEM_RD;
        end else if (store_q) begin
          state_d = S_ST_MDR;
        end else begin
          ret_d   = S_LD_DR;
          state_d = S_MEM_RD;
        end
      end

      S_LDI_MAR: begin
        GateMDR = 1'b1;
        LD_MAR  = 1'b1;
        if (store_q) begin
          state_d = S_ST_MDR;
        end else begin
          ret_d   = S_LD_DR;
          state_d = S_MEM_RD;
        end
      end

      S_LD_DR: begin
        GateMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_ST_MDR: begin
        SR1MUX  = 1'b0;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
        MIO_EN  = 1'b0;
        state_d = S_MEM_WR;
      end

      S_MEM_WR: begin
        Mem_WE = 1'b0;
        if (mem_last) begin
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_LEA: begin
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b10;
        GateMARMUX = 1'b1;
        LD_REG     = 1'b1;
        Instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = S_PAUSE2;
      end

      S_PAUSE2: begin
        LD_LED = 1'b1;
        if (!Continue) begin
          Instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end

      default: state_d = S_HALTED;
    endcase
  end

endmodule

// File: doc/isdu_param.md
Name: isdu_param

Overview:
- Parametrised successor to the sLC-3 instruction sequencer/decode unit (ISDU).
- Generates all datapath and SRAM control strobes for the sLC-3.
- Memory wait-state count is a parameter rather than hard-coded state pairs.
- Extends the opcode set with LD, ST, LDI, STI and LEA, adds a per-instruction completion pulse and an illegal-opcode flag, and makes PAUSE optional.

Parameters:
- MEM_WAIT, 2: SRAM access length in cycles, legal range 1..15. Applies to every read and write.
- PAUSE_EN, 1: 1 means opcode 1101 is PAUSE. 0 means 1101 is treated as illegal.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- Run, Continue  in  1 each  start; PAUSE handshake
- Opcode  in  4  IR[15:12]
- IR_5, IR_11, BEN  in  1 each  IR bits; branch-enable flag
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, one-hot or none
- MIO_EN  out  1  1 = MDR loads from memory; 0 = MDR loads from bus
- PCMUX  out  2  00 = PC+1, 01 = bus, 10 = adder
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each
  - DRMUX: 0 = IR[11:9], 1 = R7
  - SR1MUX: 0 = IR[11:9], 1 = IR[8:6]
  - ADDR1MUX: 0 = PC, 1 = BaseR
- ADDR2MUX  out  2  00 = 0, 01 = off6, 10 = off9, 11 = off11
- ALUK  out  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA
- Mem_CE, Mem_UB, Mem_LB  out  1 each  tied 0
- Mem_OE, Mem_WE  out  1 each  active-low
- Instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- Illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Reset: state = HALTED, wait counter = 0, all loads/gates/muxes = 0, Mem_OE = Mem_WE = 1, Instr_done = Illegal_op = 0. Reset wins over every event, including mid-access; a strobe held low must return high the cycle after Reset is sampled.
- Outputs are combinational from state only (Moore), except:
  - SR2MUX = IR_5 in ADD/AND.
  - DECODE next-state uses Opcode.
  - BR_EVAL uses BEN.
- Wait counter: width 4. Loaded with 0 on entry to any MEM_RD/MEM_WR state; increments each cycle while in it.
  - Exit when counter == MEM_WAIT-1.
  - MEM_RD: Mem_OE = 0 and MIO_EN = 1 on every cycle; LD_MDR = 1 on the final cycle only.
  - MEM_WR: Mem_WE = 0 on every cycle.
  - MEM_WAIT = 1 gives single-cycle access.
- HALTED: go to FETCH when Run = 1.
- Fetch sequence: FETCH (GatePC, LD_MAR, LD_PC, PCMUX = 00) -> MEM_RD -> LOAD_IR (GateMDR, LD_IR) -> DECODE (LD_BEN).
- Execute paths from DECODE; one memory read/write engine is shared, with a return-target register selecting the successor state:
  - ADD/AND/NOT: one state. SR1MUX = 1, GateALU, LD_REG, LD_CC. NOT uses ALUK = 10.
  - BR (0000): BR_EVAL. If BEN = 1 go to BR_TAKE (ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC), else FETCH.
  - JMP (1100): SR1MUX = 1, ALUK = 11, GateALU, PCMUX = 01, LD_PC.
  - JSR (0100): R7 <- PC (GatePC, DRMUX = 1, LD_REG), then PC <- PC+off11.
  - LD (0010): MAR <- PC+off9 (GateMARMUX), then MEM_RD, then DR <- MDR with LD_CC.
  - LDR (0110): as LD, but MAR <- BaseR+off6 (SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01).
  - LDI (1010): MAR <- PC+off9, MEM_RD, MAR <- MDR (GateMDR, LD_MAR), MEM_RD, DR <- MDR with LD_CC.
  - ST (0011) / STR (0111): MAR <- address; then MDR <- SR (SR1MUX = 0, ALUK = 11, GateALU, LD_MDR, MIO_EN = 0); then MEM_WR.
  - STI (1011): address resolution as LDI, then the store sequence.
  - LEA (1110): ADDR1MUX = 0, ADDR2MUX = 10, GateMARMUX, LD_REG. LD_CC = 0.
  - PAUSE (1101, PAUSE_EN = 1): PAUSE1 (LD_LED) holds until Continue = 1. PAUSE2 (LD_LED) holds until Continue = 0, then FETCH.
  - Illegal (1000, 1111, or 1101 with PAUSE_EN = 0): Illegal_op = 1, Instr_done = 1, next state FETCH.
- Instr_done is asserted in:
  - the final execute state;
  - BR_EVAL when BEN = 0;
  - the final MEM_WR cycle;
  - PAUSE2 when exiting.
- Never drive two Gate* signals in the same cycle. Never assert Mem_OE = 0 and Mem_WE = 0 together.
- Run is ignored outside HALTED. The unit never returns to HALTED except via Reset.

Test Plan:
- MEM_WAIT = 2, Reset then Run = 1:
  - FETCH at cycle 1.
  - Mem_OE = 0 on cycles 2-3, LD_MDR = 1 on cycle 3 only.
  - LD_IR at 4, LD_BEN at 5.
- ADD (0x1283) with MEM_WAIT = 2: exactly one execute cycle with GateALU = LD_REG = LD_CC = SR1MUX = 1 and SR2MUX = 0; Instr_done pulses; FETCH follows.
- LDI with MEM_WAIT = 3: two read bursts of 3 Mem_OE-low cycles each; LD_MAR with GateMDR between them; final LD_REG + LD_CC. Total instruction length 15 cycles.
- BR with BEN = 0: Instr_done in BR_EVAL, then FETCH. With BEN = 1: one cycle of PCMUX = 10, ADDR2MUX = 10, LD_PC = 1.
- PAUSE (0xD0A5): LD_LED held while Continue stays 0 for 10 cycles; Continue 1 -> 0 returns to FETCH. With PAUSE_EN = 0, the same opcode pulses Illegal_op once.
- STR with MEM_WAIT = 2, Reset asserted on the first Mem_WE-low cycle: the next cycle shows Mem_WE = 1, all loads = 0, state HALTED, with no further writes until Run.
